// File: rtl/fetch_sequencer.sv
// Program-fetch controller: owns the PC, strobes the combinational program memory,
// hands fetched words to decode over valid/ready, applies branch redirects and halts
// on the all-zero word. Optional `FETCH_INSTR_COUNT_EN adds a saturating handshake counter.
module fetch_sequencer #(
    parameter int unsigned              DATAWIDTH_BUS = 32,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_PC      = DATAWIDTH_BUS'(32'h0000_0800)
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_InHigh,
    input  logic                     start,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [DATAWIDTH_BUS-1:0] mem_addr,
    input  logic [DATAWIDTH_BUS-1:0] mem_data,
    output logic [DATAWIDTH_BUS-1:0] instr,
    output logic [DATAWIDTH_BUS-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     branch_take,
    input  logic [21:0]              branch_disp,
    output logic                     halted
`ifdef FETCH_INSTR_COUNT_EN
    ,
    output logic [15:0]              instr_count
`endif
);

    localparam int unsigned DISP_W = 22;
    localparam int unsigned SEXT_W = DATAWIDTH_BUS - DISP_W - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [DATAWIDTH_BUS-1:0] pc_q, pc_d;
    logic [DATAWIDTH_BUS-1:0] instr_q, instr_d;
    logic [DATAWIDTH_BUS-1:0] instr_pc_q, instr_pc_d;
    logic                     instr_valid_q, instr_valid_d;
    logic                     mem_rd_q, mem_rd_d;
    logic [DATAWIDTH_BUS-1:0] mem_addr_q, mem_addr_d;
    logic                     halted_q, halted_d;
    logic                     handshake_c;
    logic                     restart_c;
    logic [DATAWIDTH_BUS-1:0] branch_off_c;

    assign handshake_c  = (state_q == S_VALID) && instr_valid_q && instr_ready;
    assign restart_c    = ((state_q == S_IDLE) || (state_q == S_HALT)) && start;
    assign branch_off_c = {{SEXT_W{branch_disp[DISP_W-1]}}, branch_disp, 2'b00};

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = (mem_data != '0) ? S_VALID : S_HALT;
            S_VALID: if (handshake_c) state_d = S_FETCH;
            S_HALT:  if (start) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (restart_c) begin
            pc_d = RESET_PC;
        end else if (state_q == S_FETCH) begin
            if (mem_data != '0) begin
                instr_d    = mem_data;
                instr_pc_d = pc_q;
                pc_d       = pc_q + DATAWIDTH_BUS'(4);
            end
        end else if (handshake_c && branch_take) begin
            pc_d = instr_pc_q + branch_off_c;
        end
        mem_rd_d      = (state_d == S_FETCH);
        mem_addr_d    = mem_rd_d ? pc_d : '0;
        instr_valid_d = (state_d == S_VALID);
        halted_d      = (state_d == S_HALT);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            halted_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            halted_q      <= halted_d;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_wr      = 1'b0;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0] cnt_q;

    // Accepted-instruction counter, saturating
    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh || restart_c) begin
            cnt_q <= '0;
        end else if (handshake_c && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of the fetch/hand-off rules.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0800;
    localparam int          NWORDS = 15;
    localparam int M_IDLE = 0, M_FETCH = 1, M_HOLD = 2, M_HALTED = 3;

    logic        clk = 1'b0;
    logic        rst, start, instr_ready, branch_take;
    logic [21:0] branch_disp;
    logic        mem_rd, mem_wr, instr_valid, halted;
    logic [31:0] mem_addr, mem_data, instr, instr_pc;
`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    logic [31:0] prog [NWORDS];

    int          n_chk  = 0;
    int          n_pass = 0;

    int          m_mode;
    logic [31:0] m_pc, m_instr, m_ipc;
    int          m_cnt;

    always #5 clk = ~clk;

    fetch_sequencer #(.DATAWIDTH_BUS(32), .RESET_PC(RST_PC)) dut (
        .CLOCK_50     (clk),
        .RESET_InHigh (rst),
        .start        (start),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_take  (branch_take),
        .branch_disp  (branch_disp),
        .halted       (halted)
`ifdef FETCH_INSTR_COUNT_EN
        ,
        .instr_count  (instr_count)
`endif
    );

    // Program image at RST_PC, one extra word at the top of the address space, rest reads 0
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a == 32'hFFFF_FFFC) return 32'h0BAD_F00D;
        if (a >= RST_PC && a < RST_PC + 32'(4 * NWORDS) && a[1:0] == 2'b00)
            return prog[int'((a - RST_PC) >> 2)];
        return 32'h0;
    endfunction

    assign mem_data = mem_read(mem_addr);

    function automatic int disp_words(input logic [21:0] d);
        return d[21] ? int'(d) - 4194304 : int'(d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Effect of the upcoming clock edge, given the inputs currently driven
    task automatic model_step();
        logic [31:0] w;
        if (rst) begin
            m_mode = M_IDLE; m_pc = RST_PC; m_instr = 0; m_ipc = 0; m_cnt = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_HALTED: if (start) begin
                    m_pc = RST_PC; m_mode = M_FETCH; m_cnt = 0;
                end
                M_FETCH: begin
                    w = mem_read(m_pc);
                    if (w != 0) begin
                        m_instr = w; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_mode = M_HOLD;
                    end else begin
                        m_mode = M_HALTED;
                    end
                end
                M_HOLD: if (instr_ready) begin
                    m_mode = M_FETCH;
                    if (m_cnt < 65535) m_cnt++;
                    if (branch_take) m_pc = m_ipc + 32'(disp_words(branch_disp) * 4);
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic check_all();
        chk("mem_rd", 32'(mem_rd), 32'(m_mode == M_FETCH));
        chk("mem_wr", 32'(mem_wr), 32'h0);
        chk("mem_addr", mem_addr, (m_mode == M_FETCH) ? m_pc : 32'h0);
        chk("instr_valid", 32'(instr_valid), 32'(m_mode == M_HOLD));
        chk("halted", 32'(halted), 32'(m_mode == M_HALTED));
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
`ifdef FETCH_INSTR_COUNT_EN
        chk("instr_count", 32'(instr_count), 32'(m_cnt));
`endif
    endtask

    task automatic cycle(input logic r, input logic s, input logic rdy,
                         input logic bt, input logic [21:0] d);
        rst = r; start = s; instr_ready = rdy; branch_take = bt; branch_disp = d;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        prog[0] = 32'h8280_2001;
        for (int i = 1; i < 13; i++) prog[i] = $urandom() | 32'h1;
        prog[13] = 32'h10BF_FFFB;
        prog[14] = 32'h0;

        rst = 1'b1; start = 1'b0; instr_ready = 1'b0; branch_take = 1'b0; branch_disp = 22'h0;
        model_step();
        @(negedge clk);
        check_all();

        // Start and first fetch
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 22'h0);
        chk("tp_first_rd", 32'(mem_rd), 32'h1);
        chk("tp_first_addr", mem_addr, 32'h800);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 22'h0);
        chk("tp_first_instr", instr, 32'h8280_2001);
        chk("tp_first_pc", instr_pc, 32'h800);

        // Backpressure; branch_take without handshake must be ignored
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 22'h3FFFFB);
            chk("tp_bp_instr", instr, 32'h8280_2001);
            chk("tp_bp_rd", 32'(mem_rd), 32'h0);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 22'h0);
        chk("tp_seq_addr", mem_addr, 32'h804);

        // Run sequentially to the branch word at 0x834
        for (int i = 0; i < 200; i++) begin
            if (m_mode == M_HOLD && m_ipc == 32'h834) break;
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 22'h0);
        end
        chk("tp_branch_word", instr, 32'h10BF_FFFB);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 22'h3FFFFB);
        chk("tp_branch_addr", mem_addr, 32'h820);
`ifdef FETCH_INSTR_COUNT_EN
        chk("tp_count14", 32'(instr_count), 32'd14);
`endif

        // Fall through to the zero word at 0x838
        for (int i = 0; i < 200; i++) begin
            if (m_mode == M_HALTED) break;
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 22'h0);
        end
        chk("tp_halted", 32'(halted), 32'h1);
        chk("tp_halt_novalid", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 22'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 22'h0);
        chk("tp_restart_addr", mem_addr, 32'h800);
        chk("tp_restart_halted", 32'(halted), 32'h0);
`ifdef FETCH_INSTR_COUNT_EN
        chk("tp_count_clr", 32'(instr_count), 32'h0);
`endif

        // Reset wins over a handshake in VALID
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 22'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 22'h1);
        chk("tp_rst_valid", 32'(instr_valid), 32'h0);
        chk("tp_rst_rd", 32'(mem_rd), 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 22'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 22'h0);

        // Branch target wraps below zero, then pc+4 wraps to 0
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 22'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 22'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 22'h3FFDFF);
        chk("tp_wrap_target", mem_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 22'h0);
        chk("tp_wrap_instr", instr, 32'h0BAD_F00D);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 22'h0);
        chk("tp_wrap_rd", 32'(mem_rd), 32'h1);
        chk("tp_wrap_addr", mem_addr, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 22'h0);
        chk("tp_wrap_halt", 32'(halted), 32'h1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0),
                  22'(int'($urandom_range(0, 32)) - 16));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-fetch controller for the micro datapath. It owns the program counter and drives the read strobe and address of the combinational program memory. It captures each returned instruction word and presents it to the decode stage over a valid/ready handshake. It also applies taken-branch redirects and stops fetching when it reads the all-zero end-of-program word.

## Interface

Parameters:
- DATAWIDTH_BUS, 32: width of the address bus, data bus and PC.
- RESET_PC, 32'h0000_0800: first fetch address after reset or start.

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- RESET_InHigh  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle pulse that begins or restarts fetching at RESET_PC.
- mem_rd  out  1  program memory read strobe.
- mem_wr  out  1  program memory write strobe; constant 0.
- mem_addr  out  DATAWIDTH_BUS  program memory address.
- mem_data  in  DATAWIDTH_BUS  program memory read data; combinational from mem_addr.
- instr  out  DATAWIDTH_BUS  captured instruction word.
- instr_pc  out  DATAWIDTH_BUS  address that instr was fetched from.
- instr_valid  out  1  instr and instr_pc are valid.
- instr_ready  in  1  decode stage accepts instr this cycle.
- branch_take  in  1  redirect fetch; sampled only on a handshake.
- branch_disp  in  22  signed word displacement, relative to instr_pc.
- halted  out  1  end-of-program word was fetched.

## Operation

- States: IDLE, FETCH, VALID, HALT. Reset state is IDLE.
- Reset values: pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, mem_rd=0, mem_addr=0, halted=0.
- mem_addr equals pc while mem_rd=1, and 0 otherwise.
- IDLE: mem_rd=0. On start, pc<=RESET_PC and the state moves to FETCH.
- FETCH: mem_rd=1 for exactly one cycle. mem_data is sampled at the closing edge.
  - If mem_data≠0: instr<=mem_data, instr_pc<=pc, pc<=pc+4, instr_valid<=1, state moves to VALID.
  - If mem_data==0: halted<=1, instr_valid stays 0, state moves to HALT.
- VALID: mem_rd=0. instr, instr_pc and instr_valid are held stable until instr_valid & instr_ready (a handshake).
  - On a handshake: instr_valid<=0 and the state moves to FETCH.
  - If branch_take=1 in that same cycle: pc <= instr_pc + ({{8{branch_disp[21]}}, branch_disp, 2'b00}).
  - Otherwise pc keeps its value, which is already the sequential next address.
- HALT: mem_rd=0, halted=1. start clears halted, sets pc<=RESET_PC and moves to FETCH. Only reset or start leave this state.
- PC arithmetic is modulo 2^DATAWIDTH_BUS. pc+4 from 32'hFFFF_FFFC wraps to 0, and so does a branch target computation.
- start in FETCH or VALID is ignored.
- branch_take without a handshake is ignored.
- Unmapped addresses read as 0 and therefore halt.

## Timing

- The edge that samples start ends the start cycle (cycle 0). mem_rd=1 in cycle 1; instr_valid=1 from cycle 2.
- Fetch latency is 1 cycle. Peak throughput is one instruction per 2 cycles with instr_ready held at 1.
- Handshake in cycle n: mem_rd=1 with the new pc in cycle n+1, and the next instr_valid=1 in cycle n+2.
- Reset asserted in any state: at the next edge all outputs take their reset values and the state becomes IDLE. Reset has priority over start and over a handshake in the same cycle.
- mem_rd, mem_addr, instr_valid and halted are registered or decoded from state only. None of them depends combinationally on any input.

## Configuration

- FETCH_INSTR_COUNT_EN defined: adds output instr_count, 16 bits.
  - It increments on each handshake and saturates at 16'hFFFF.
  - Reset and start set it to 0.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan

- Reset then start, instr_ready=1, memory word at 0x800 is 0x82802001 → cycle 1: mem_rd=1, mem_addr=0x800. Cycle 2: instr_valid=1, instr=0x82802001, instr_pc=0x800.
- Backpressure: instr_ready=0 for 5 cycles after valid → instr/instr_pc stable and mem_rd=0 throughout. After ready rises, the next fetch is at 0x804.
- Branch: handshake on instr_pc=0x834 (word 0x10BFFFFB) with branch_take=1, branch_disp=22'h3FFFFB (−5) → next mem_addr=0x820.
- End of program: fetch at 0x838 returns 0 → halted=1 and instr_valid stays 0. mem_rd stays 0 until start, then fetching restarts at 0x800.
- Reset mid-operation: RESET_InHigh asserted in VALID together with instr_ready=1 → next cycle IDLE, instr_valid=0, pc=0x800, no fetch issued.
- With FETCH_INSTR_COUNT_EN: 14 sequential handshakes from 0x800 → instr_count=14. A following start → instr_count=0.
